// File: rtl/data_mem_pkg.sv
`timescale 1ns/1ps
// Shared defaults for the data memory: word/address widths and the word type.
package data_mem_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/data_mem_if.sv
`timescale 1ns/1ps
// Bus between a data-memory user (master) and the data memory (slave).
interface data_mem_if
  import data_mem_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int A = ADDR_W
);
  logic [A-1:0] DataAddress;
  logic         ReadMem;
  logic         WriteMem;
  logic [W-1:0] DataIn;
  logic [W-1:0] DataOut;

  modport master (
    output DataAddress, ReadMem, WriteMem, DataIn,
    input  DataOut
  );

  modport slave (
    input  DataAddress, ReadMem, WriteMem, DataIn,
    output DataOut
  );
endinterface

// File: rtl/data_mem.sv
`timescale 1ns/1ps
// Single-port data memory: synchronous write, combinational read,
// asynchronous active-low clear of the whole array.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int A = ADDR_W
)
(
  input logic      clk,
  input logic      reset,
  data_mem_if.slave bus
);

  logic [W-1:0] mem_core [0:(2**A)-1];

  // Plain always rather than always_ff so mem_core can also be
  // assigned hierarchically from outside as a backdoor.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**A; i++) begin
        mem_core[i] <= '0;
      end
    end else if (bus.WriteMem) begin
      mem_core[bus.DataAddress] <= bus.DataIn;
    end
  end

  assign bus.DataOut = bus.ReadMem ? mem_core[bus.DataAddress] : '0;

endmodule

// File: tb/tb_data_mem.sv
`timescale 1ns/1ps
// Self-checking bench for data_mem: array reference model plus directed vectors.
module tb_data_mem;
  import data_mem_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  bit   done;
  word_t model [256];
  word_t exp_out;

  data_mem_if #(.W(DATA_W), .A(ADDR_W)) bus ();

  data_mem #(.W(DATA_W), .A(ADDR_W)) data_mem1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: an array that takes port writes at qualifying edges and is
  // wiped whenever reset goes low.
  always @(posedge clk) begin
    if (reset && bus.WriteMem) model[bus.DataAddress] = bus.DataIn;
  end

  always @(negedge reset) begin
    for (int i = 0; i < 256; i++) model[i] = '0;
  end

  task automatic checkOutput(input string name, input word_t got, input word_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] addr,
                               input word_t data);
    bus.WriteMem    = wr;
    bus.ReadMem     = rd;
    bus.DataAddress = addr;
    bus.DataIn      = data;
  endtask

  // Mid-cycle point: 2ns after a rising edge, well clear of both edges.
  task automatic midCycle();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (!done) begin
      exp_out = bus.ReadMem ? model[bus.DataAddress] : '0;
      checkOutput("cycle_dataout", bus.DataOut, exp_out);
    end
  end

  initial begin
    done  = 1'b0;
    tests = 0;
    fails = 0;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 8'h05, 8'h00);
    #1;
    checkOutput("reset_dataout", bus.DataOut, 8'h00);

    // Put a nonzero word in, then pulse reset between edges.
    midCycle();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'h07, 8'h11);
    midCycle();
    applyStimulus(1'b0, 1'b1, 8'h07, 8'h00);
    #1;
    checkOutput("pre_pulse_read", bus.DataOut, 8'h11);
    reset = 1'b0;
    #1;
    checkOutput("pulse_dataout", bus.DataOut, 8'h00);
    for (int i = 0; i < 256; i++) begin
      checkOutput("pulse_clear", data_mem1.mem_core[i], 8'h00);
    end
    reset = 1'b1;

    // Two port writes, then read both back.
    midCycle();
    applyStimulus(1'b1, 1'b1, 8'h00, 8'hA5);
    midCycle();
    applyStimulus(1'b1, 1'b1, 8'h01, 8'h3C);
    midCycle();
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
    #1;
    checkOutput("read_addr0", bus.DataOut, 8'hA5);
    bus.DataAddress = 8'h01;
    #1;
    checkOutput("read_addr1", bus.DataOut, 8'h3C);
    checkOutput("core_word0", data_mem1.mem_core[0], 8'hA5);
    checkOutput("core_word1", data_mem1.mem_core[1], 8'h3C);
    checkOutput("model_pin0", model[0], 8'hA5);

    // Backdoor writes visible on the read port without a clock edge.
    midCycle();
    data_mem1.mem_core[2] <= 8'h7F;
    data_mem1.mem_core[3] <= 8'h80;
    model[2] = 8'h7F;
    model[3] = 8'h80;
    bus.DataAddress = 8'h02;
    #1;
    checkOutput("backdoor_addr2", bus.DataOut, 8'h7F);
    bus.DataAddress = 8'h03;
    #1;
    checkOutput("backdoor_addr3", bus.DataOut, 8'h80);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("backdoor_persist", data_mem1.mem_core[2], 8'h7F);

    // WriteMem low must not disturb contents.
    applyStimulus(1'b0, 1'b0, 8'h10, 8'hFF);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("no_write_addr16", data_mem1.mem_core[16], 8'h00);

    // Read-during-write at the top address.
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'h55);
    #1;
    checkOutput("rdw_before_edge", bus.DataOut, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("rdw_after_edge", bus.DataOut, 8'h55);
    bus.WriteMem = 1'b0;
    bus.ReadMem  = 1'b0;
    #1;
    checkOutput("read_disabled", bus.DataOut, 8'h00);
    checkOutput("core_word255", data_mem1.mem_core[255], 8'h55);

    // Fill every address with its own index.
    midCycle();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(i), 8'(i));
      midCycle();
    end
    applyStimulus(1'b0, 1'b1, 8'hC3, 8'h00);
    #1;
    checkOutput("fill_read_c3", bus.DataOut, 8'hC3);
    checkOutput("model_pin_c3", model[8'hC3], 8'hC3);

    // Reset wipes the filled array and blocks writes while held.
    reset = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) begin
      checkOutput("fill_clear", data_mem1.mem_core[i], 8'h00);
    end
    applyStimulus(1'b1, 1'b1, 8'h20, 8'h99);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("write_in_reset", data_mem1.mem_core[32], 8'h00);
    checkOutput("dataout_in_reset", bus.DataOut, 8'h00);

    // First write after release lands on the next rising edge.
    applyStimulus(1'b1, 1'b1, 8'h21, 8'h42);
    reset = 1'b1;
    #1;
    checkOutput("post_release_pre", data_mem1.mem_core[33], 8'h00);
    @(posedge clk);
    #1;
    checkOutput("post_release_write", data_mem1.mem_core[33], 8'h42);
    checkOutput("post_release_keep", data_mem1.mem_core[32], 8'h00);
    bus.WriteMem = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
